// File: rtl/clk_enable_multi.sv
// Multi-channel programmable clock-enable generator: per-channel divider, mode
// (off / periodic / one-shot), single-cycle strobe and toggling square output.
module clk_enable_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 5,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock_5,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [1:0]        cfg_mode,
  input  logic [NUM_CH-1:0] start,
  input  logic              sync_restart,
  output logic [NUM_CH-1:0] enable_out,
  output logic [NUM_CH-1:0] square_out,
  output logic [NUM_CH-1:0] busy
);

  typedef enum logic [1:0] {
    MODE_OFF      = 2'b00,
    MODE_PERIODIC = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_RSVD     = 2'b11
  } mode_t;

  logic [CNT_W-1:0] div_q   [NUM_CH];
  mode_t            mode_q  [NUM_CH];
  logic [CNT_W-1:0] count_q [NUM_CH];

  always_ff @(posedge clock_5) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (!reset) begin
        div_q[i]      <= CNT_W'(DEFAULT_DIV);
        mode_q[i]     <= MODE_PERIODIC;
        count_q[i]    <= '0;
        enable_out[i] <= 1'b0;
        square_out[i] <= 1'b0;
        busy[i]       <= 1'b0;
      end else if (cfg_we && (int'(cfg_ch) == i)) begin
        // Out-of-range channel numbers never match any i, so those writes drop.
        div_q[i]      <= cfg_div;
        mode_q[i]     <= mode_t'(cfg_mode);
        count_q[i]    <= '0;
        enable_out[i] <= 1'b0;
        busy[i]       <= 1'b0;
      end else if (sync_restart) begin
        count_q[i]    <= '0;
        enable_out[i] <= 1'b0;
      end else begin
        case (mode_q[i])
          MODE_PERIODIC: begin
            if (count_q[i] == div_q[i]) begin
              enable_out[i] <= 1'b1;
              count_q[i]    <= '0;
              square_out[i] <= ~square_out[i];
            end else begin
              enable_out[i] <= 1'b0;
              count_q[i]    <= count_q[i] + 1'b1;
            end
          end
          MODE_ONESHOT: begin
            if (!busy[i]) begin
              enable_out[i] <= 1'b0;
              count_q[i]    <= '0;
              busy[i]       <= start[i];
            end else if (count_q[i] == div_q[i]) begin
              // Terminal cycle: start is deliberately not looked at here.
              enable_out[i] <= 1'b1;
              count_q[i]    <= '0;
              square_out[i] <= ~square_out[i];
              busy[i]       <= 1'b0;
            end else begin
              enable_out[i] <= 1'b0;
              count_q[i]    <= count_q[i] + 1'b1;
            end
          end
          default: begin
            enable_out[i] <= 1'b0;
            count_q[i]    <= '0;
            busy[i]       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/clk_enable_multi.md
# clk_enable_multi

Multi-channel programmable clock-enable generator, the parametrised successor to the team's single-channel fixed-divider enable block. It produces NUM_CH independent single-cycle enable strobes from clock_5, each with a run-time divider and mode (off / periodic / one-shot), plus a per-channel square-wave output. It sits beside the system clock and gates slow logic such as display refresh, debouncers and step timers, so that everything runs in one clock domain.

## Interface

- NUM_CH, default 4: number of independent channels (1..16).
- CNT_W, default 32: counter and divider width.
- DEFAULT_DIV, default 5: divider loaded into every channel at reset.
- CH_W, default $clog2(NUM_CH) (minimum 1): channel-select width.

- clock_5  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-low reset.
- cfg_we  in  1  configuration write strobe.
- cfg_ch  in  CH_W  channel addressed by the write.
- cfg_div  in  CNT_W  new divider D; period = D+1 cycles.
- cfg_mode  in  2  new mode: 00 off, 01 periodic, 10 one-shot, 11 reserved (behaves as off).
- start  in  NUM_CH  per-channel one-shot trigger, level-sampled each cycle.
- sync_restart  in  1  phase-align: zeroes all channel counters.
- enable_out  out  NUM_CH  registered single-cycle enable strobes.
- square_out  out  NUM_CH  registered level; toggles on each strobe.
- busy  out  NUM_CH  one-shot in progress.

## Operation

- Each channel holds the registers div[CNT_W], mode[2], count[CNT_W], busy, enable_out and square_out.
- Reset (reset=0 at an edge) has top priority. It sets div=DEFAULT_DIV, mode=01 (periodic), count=0, and enable_out, square_out and busy all to 0.
- Priority per channel at each edge: reset > config write to this channel > sync_restart > normal operation.
- Config write (cfg_we=1, cfg_ch<NUM_CH):
  - Loads div and mode.
  - Sets count=0, enable_out=0 and busy=0.
  - Leaves square_out unchanged.
  - If cfg_ch>=NUM_CH, the write is ignored entirely.
- sync_restart=1: every channel not being written gets count=0 and enable_out=0. Mode, div, busy and square_out are unchanged.
- Off mode: count is held at 0, enable_out=0, busy=0, and square_out holds its value.
- Periodic mode:
  - If count==div: enable_out<=1, count<=0, square_out<=~square_out.
  - Otherwise: enable_out<=0, count<=count+1.
- One-shot mode:
  - Idle (busy=0): count is held at 0 and enable_out=0. If start[i]=1, then busy<=1 and count<=0.
  - Busy: uses the periodic terminal rule. At terminal it also sets busy<=0.
  - start[i] is ignored while busy=1, including the terminal cycle.
- D=0 boundaries:
  - Periodic: enable_out is continuously 1 and square_out toggles every cycle.
  - One-shot: pulses on the cycle after the start is sampled.
- Counter compare is full-width unsigned. The count never exceeds div, so no wrap-around occurs. D = 2^CNT_W−1 is legal.
- Channels are fully independent. There is no shared state apart from cfg and sync_restart.

## Timing

- All outputs are registered, with no combinational path from inputs to outputs.
- Periodic, from reset release or a write, with divider D: the strobe is high for the cycle following edge D+1, then every D+1 cycles. For D=5, it is high after edges 6, 12, 18, …
- One-shot: start is sampled at edge s. busy is high from edge s to edge s+1+D. enable_out is high for exactly one cycle, after edge s+1+D.
- A write takes effect at its own edge. The channel's next strobe is D+1 edges later.
- Reset mid-operation aborts any one-shot (busy drops at the same edge) and restores the DEFAULT_DIV periodic behaviour.
- Strobe duty cycle is always exactly 1 cycle high, except when D=0.

## Test plan

- Reset release with defaults: all NUM_CH channels strobe after edges 6, 12, 18, and square_out is high after edge 6 and low after edge 12.
- Write ch1 div=2, mode=01 mid-count: ch1 strobes 3, 6, 9 edges after the write edge, while the other channels keep their original phase.
- Write ch2 mode=10 div=3, then pulse start[2] at edge s:
  - busy[2] is high from s to s+4, and exactly one strobe appears after edge s+4.
  - A second start at s+2 is ignored.
- sync_restart asserted with channels at differing counts: all channels at div=5 next strobe together, 6 edges later. A concurrent write to ch0 overrides the restart for ch0.
- D=0 periodic: enable_out is stuck at 1 and square_out alternates every cycle. Mode 11 and mode 00 give constant 0 and a frozen square_out.
- Reset asserted during a busy one-shot and during a pending write: all outputs are 0 after that edge, and div is back to 5.
